// File: rtl/wb_spi_mem_pkg.sv
// ============================================================================
// Module      : wb_spi_mem_pkg
// Description : Shared types, constants and helpers for the Wishbone-to-SPI
//               SRAM bridge (FSM states, SRAM mode-register constants,
//               byte-span decode from the Wishbone byte enables).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_spi_mem_pkg;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_CMD  = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // SRAM mode-register write: command byte and "sequential mode" value
  localparam logic [7:0] C_MODE_WRMR = 8'h01;
  localparam logic [7:0] C_MODE_SEQ  = 8'h40;

  // Shifter geometry: 32-bit left-aligned frame, bit count up to 32
  localparam int C_SHIFT_W = 32;
  localparam int C_CNT_W   = 6;

  // Contiguous byte span covered by a set of byte enables
  typedef struct packed {
    logic [1:0] lo;  // lowest enabled lane
    logic [2:0] n;   // lanes from lo up to highest enabled lane, inclusive
  } span_t;

  // Lowest/highest enabled lane and span length; sel=0 yields a harmless 1
  function automatic span_t sel_span(input logic [3:0] sel);
    span_t      s;
    logic [1:0] hi;
    s.lo = 2'd0;
    hi   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) s.lo = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) hi = 2'(i);
    end
    s.n = {1'b0, hi} - {1'b0, s.lo} + 3'd1;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_ctl.sv
// ============================================================================
// Module      : spi_shift_ctl
// Description : Mode-0 bit-serial shifter. Each bit spends one clock with
//               sclk low (L) and one with sclk high (H); MISO is captured on
//               the edge that ends H. o_done flags the final H phase so the
//               parent can load the next frame segment without a gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_ctl
  import wb_spi_mem_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [C_CNT_W-1:0]   i_width,
  input  logic [C_SHIFT_W-1:0] i_data,
  input  logic                 i_miso,
  output logic                 o_sclk,
  output logic                 o_mosi,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [C_SHIFT_W-1:0] o_rx
);

  logic [C_SHIFT_W-1:0] r_sh;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_phase;
  logic                 r_busy;
  logic [C_SHIFT_W-1:0] r_rx;

  // Phase toggle, transmit shift and bit countdown; a load restarts at phase L
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_sh    <= i_data;
      r_cnt   <= i_width;
      r_phase <= 1'b0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_sh    <= {r_sh[C_SHIFT_W-2:0], 1'b0};
        r_cnt   <= r_cnt - 1'b1;
        if (r_cnt == C_CNT_W'(1)) r_busy <= 1'b0;
      end
    end
  end

  // Receive shift: one MISO bit at the end of every H phase, even on a reload edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx <= '0;
    end else if (r_busy && r_phase) begin
      r_rx <= {r_rx[C_SHIFT_W-2:0], i_miso};
    end
  end

  assign o_sclk = r_phase;
  assign o_mosi = r_busy ? r_sh[C_SHIFT_W-1] : 1'b0;
  assign o_busy = r_busy;
  assign o_done = r_busy && r_phase && (r_cnt == C_CNT_W'(1));
  assign o_rx   = r_rx;

endmodule

`default_nettype wire

// File: rtl/wb_spi_mem.sv
// ============================================================================
// Module      : wb_spi_mem
// Description : Wishbone responder backed by a serial SPI SRAM (mode 0).
//               Every bus cycle becomes one command/address/data SPI frame
//               covering the enabled byte span; ack fires when the frame ends.
//               Optional macro WB_SPI_MEM_INIT_EN: after reset, write the
//               SRAM mode register (sequential mode) before serving requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_spi_mem
  import wb_spi_mem_pkg::*;
#(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] CMD_RD = 8'h03,
  parameter logic [7:0] CMD_WR = 8'h02
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_spi_sclk,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

`ifdef WB_SPI_MEM_INIT_EN
  localparam state_t C_RST_STATE = ST_INIT;
`else
  localparam state_t C_RST_STATE = ST_IDLE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:2]   r_adr;
  logic [31:0]         r_dat;
  logic                r_we;
  logic [1:0]          r_lo;
  logic [2:0]          r_n;
  logic                r_cs_n;
  logic                r_ack;
  logic [31:0]         r_rdt;

  logic                w_accept;
  span_t               w_span;
  logic                w_load;
  logic [C_CNT_W-1:0]  w_width;
  logic [31:0]         w_data;
  logic                w_done;
  logic                w_busy;
  logic                w_sclk;
  logic                w_mosi;
  logic [31:0]         w_rx;
  logic [ADDR_W-1:0]   w_spi_addr;
  logic [31:0]         w_wr_stream;
  logic [31:0]         w_rd_word;
  logic [7:0]          w_dat_b [4];
  logic [7:0]          w_rx_b  [4];

  // Address bits outside the SRAM window and the byte offset are ignored
  logic w_unused_adr;
  assign w_unused_adr = ^{i_wb_adr[31:ADDR_W], i_wb_adr[1:0]};

  assign w_accept   = (r_state == ST_IDLE) && i_wb_cyc && !r_ack;
  assign w_span     = sel_span(i_wb_sel);
  assign w_spi_addr = {r_adr, 2'b00} + ADDR_W'(r_lo);

  // Byte views of the latched write data and the received shift register
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_dat_b[j] = r_dat[8*j +: 8];
      w_rx_b[j]  = w_rx[8*j +: 8];
    end
  end

  // Write payload: lanes lo..lo+n-1 in ascending order, left-aligned MSB first
  always_comb begin
    w_wr_stream = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < r_n) w_wr_stream[31-8*k -: 8] = w_dat_b[r_lo + 2'(k)];
    end
  end

  // Read word: received byte k lands in lane lo+k; the last byte is rx[7:0]
  always_comb begin
    w_rd_word = '0;
    for (int l = 0; l < 4; l++) begin
      if ((2'(l) >= r_lo) && ({1'b0, 2'(l) - r_lo} < r_n))
        w_rd_word[8*l +: 8] = w_rx_b[2'(r_n - 3'd1 - {1'b0, 2'(l) - r_lo})];
    end
  end

  // Sequencer state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= C_RST_STATE;
    else       r_state <= w_next;
  end

  // Next state and per-segment shifter loads (command, address, data)
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_width = '0;
    w_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_wb_sel != 4'b0000)) begin
          w_next  = ST_CMD;
          w_load  = 1'b1;
          w_width = C_CNT_W'(8);
          w_data  = {(i_wb_we ? CMD_WR : CMD_RD), 24'h000000};
        end
      end
      ST_INIT: begin
`ifdef WB_SPI_MEM_INIT_EN
        if (!w_busy) begin
          w_load  = 1'b1;
          w_width = C_CNT_W'(16);
          w_data  = {C_MODE_WRMR, C_MODE_SEQ, 16'h0000};
        end else if (w_done) begin
          w_next = ST_IDLE;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      ST_CMD: begin
        if (w_done) begin
          w_next  = ST_ADDR;
          w_load  = 1'b1;
          w_width = C_CNT_W'(ADDR_W);
          w_data  = {w_spi_addr, {(32-ADDR_W){1'b0}}};
        end
      end
      ST_ADDR: begin
        if (w_done) begin
          w_next  = ST_DATA;
          w_load  = 1'b1;
          w_width = {r_n, 3'b000};
          w_data  = r_we ? w_wr_stream : 32'h0;
        end
      end
      ST_DATA: begin
        if (w_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, chip select, ack pulse and read-data update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_adr  <= '0;
      r_dat  <= '0;
      r_we   <= 1'b0;
      r_lo   <= '0;
      r_n    <= '0;
      r_cs_n <= 1'b1;
      r_ack  <= 1'b0;
      r_rdt  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_adr <= i_wb_adr[ADDR_W-1:2];
            r_dat <= i_wb_dat;
            r_we  <= i_wb_we;
            r_lo  <= w_span.lo;
            r_n   <= w_span.n;
            if (i_wb_sel == 4'b0000) r_ack  <= 1'b1;
            else                     r_cs_n <= 1'b0;
          end
        end
        ST_INIT: begin
          if (w_load)      r_cs_n <= 1'b0;
          else if (w_done) r_cs_n <= 1'b1;
        end
        ST_DONE: begin
          r_cs_n <= 1'b1;
          r_ack  <= i_wb_cyc;
          if (!r_we) r_rdt <= w_rd_word;
        end
        default: begin
        end
      endcase
    end
  end

  spi_shift_ctl u_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_width (w_width),
    .i_data  (w_data),
    .i_miso  (i_spi_miso),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_rx    (w_rx)
  );

  assign o_wb_rdt   = r_rdt;
  assign o_wb_ack   = r_ack;
  assign o_spi_sclk = w_sclk;
  assign o_spi_cs_n = r_cs_n;
  assign o_spi_mosi = w_mosi;

endmodule

`default_nettype wire

// File: tb/tb_wb_spi_mem.sv
// ============================================================================
// Module      : tb_wb_spi_mem
// Description : Directed self-checking bench for wb_spi_mem with a 23LC-style
//               SPI SRAM model (16-bit address, read 0x03 / write 0x02).
//               Honours WB_SPI_MEM_INIT_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_spi_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] rdt_o;
  logic        ack;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_spi_mem #(.ADDR_W(16), .CMD_RD(8'h03), .CMD_WR(8'h02)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_adr   (wb_adr),
    .i_wb_dat   (wb_dat),
    .i_wb_sel   (wb_sel),
    .i_wb_we    (wb_we),
    .i_wb_cyc   (wb_cyc),
    .o_wb_rdt   (rdt_o),
    .o_wb_ack   (ack),
    .o_spi_sclk (sclk),
    .o_spi_cs_n (cs_n),
    .o_spi_mosi (mosi),
    .i_spi_miso (miso)
  );

  // SRAM model: rom feeds reads, wmem records writes, log_b records every MOSI byte
  logic [7:0]  rom  [0:65535];
  logic [7:0]  wmem [0:65535];
  logic [7:0]  log_b [0:1023];
  int          log_n  = 0;
  int          bitcnt = 0;
  logic [7:0]  s_sh   = 8'h00;
  logic [7:0]  s_cmd  = 8'h00;
  logic [15:0] s_addr = 16'h0000;
  logic [15:0] s_a;
  logic [7:0]  s_tmp;

  // Slave works on the falling system clock: exactly one per sclk-high phase
  always @(negedge clk) begin
    if (cs_n) begin
      bitcnt = 0;
    end else if (sclk) begin
      s_sh = {s_sh[6:0], mosi};
      if (bitcnt >= 24 && s_cmd == 8'h03) begin
        s_a   = s_addr + 16'((bitcnt - 24) / 8);
        s_tmp = rom[s_a];
        miso  = s_tmp[7 - (bitcnt % 8)];
      end
      bitcnt++;
      if (bitcnt % 8 == 0) begin
        log_b[log_n % 1024] = s_sh;
        log_n++;
        case (bitcnt / 8)
          1: s_cmd = s_sh;
          2: s_addr[15:8] = s_sh;
          3: s_addr[7:0]  = s_sh;
          default: if (s_cmd == 8'h02) wmem[s_addr + 16'(bitcnt / 8 - 4)] = s_sh;
        endcase
      end
    end
  end

  function automatic logic [7:0] lg(input int i);
    return log_b[i % 1024];
  endfunction

  // One Wishbone cycle; lat = edges from raising cyc until ack is seen (-1 on timeout)
  task automatic do_xfer(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we,
                         output int lat, output logic [31:0] rd,
                         output logic cs_seen);
    lat = -1; rd = 32'h0; cs_seen = 1'b0;
    @(posedge clk); #1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (!cs_n) cs_seen = 1'b1;
      if (ack) begin lat = k; rd = rdt_o; break; end
    end
    wb_cyc = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
  endtask

  // With the init feature, wait for the mode-register frame after a reset
  task automatic wait_init();
`ifdef WB_SPI_MEM_INIT_EN
    int t;
    t = 0;
    while (cs_n && t < 100) begin @(posedge clk); #1; t++; end
    while (!cs_n && t < 200) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t >= 200) begin n_fail++; $display("FAIL init_wait: cycles %0d, required < 200", t); end
`endif
  endtask

  task automatic test_reset();
    int lat;
    int s;
    rst = 1'b1; wb_cyc = 1'b0; wb_adr = 0; wb_dat = 0; wb_sel = 0; wb_we = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ack !== 1'b0)      begin n_fail++; $display("FAIL reset_ack: got %b required 0", ack); end
    n_checks++; if (rdt_o !== 32'h0)   begin n_fail++; $display("FAIL reset_rdt: got %h required 0", rdt_o); end
    n_checks++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL reset_cs_n: got %b required 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk: got %b required 0", sclk); end
    n_checks++; if (mosi !== 1'b0)     begin n_fail++; $display("FAIL reset_mosi: got %b required 0", mosi); end
`ifdef WB_SPI_MEM_INIT_EN
    s = log_n;
    wb_adr = 32'h1234; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1;
    rst = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (ack) begin lat = k; break; end
    end
    n_checks++; if (lat < 0)               begin n_fail++; $display("FAIL init_req_ack: no ack within 400 cycles"); end
    n_checks++; if (lg(s) !== 8'h01)       begin n_fail++; $display("FAIL init_byte0: got %h required 01", lg(s)); end
    n_checks++; if (lg(s+1) !== 8'h40)     begin n_fail++; $display("FAIL init_byte1: got %h required 40", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'h03)     begin n_fail++; $display("FAIL init_req_cmd: got %h required 03", lg(s+2)); end
    n_checks++; if (rdt_o !== 32'h44332211) begin n_fail++; $display("FAIL init_req_rdt: got %h required 44332211", rdt_o); end
    wb_cyc = 1'b0; wb_sel = 4'h0;
`else
    s = 0; lat = 0;
    rst = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_word_read();
    int lat; logic [31:0] rd; logic cs; int s;
    s = log_n;
    do_xfer(32'h0000_1234, 32'h0, 4'hF, 1'b0, lat, rd, cs);
    n_checks++; if (lat !== 114)          begin n_fail++; $display("FAIL word_read_lat: got %0d required 114", lat); end
    n_checks++; if (rd !== 32'h44332211)  begin n_fail++; $display("FAIL word_read_rdt: got %h required 44332211", rd); end
    n_checks++; if (lg(s) !== 8'h03)      begin n_fail++; $display("FAIL word_read_cmd: got %h required 03", lg(s)); end
    n_checks++; if (lg(s+1) !== 8'h12)    begin n_fail++; $display("FAIL word_read_ahi: got %h required 12", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'h34)    begin n_fail++; $display("FAIL word_read_alo: got %h required 34", lg(s+2)); end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd; logic cs; int s;
    s = log_n;
    do_xfer(32'h0000_0100, 32'hAABBCCDD, 4'b0100, 1'b1, lat, rd, cs);
    n_checks++; if (lat !== 66)              begin n_fail++; $display("FAIL byte_write_lat: got %0d required 66", lat); end
    n_checks++; if (lg(s) !== 8'h02)         begin n_fail++; $display("FAIL byte_write_cmd: got %h required 02", lg(s)); end
    n_checks++; if (lg(s+1) !== 8'h01)       begin n_fail++; $display("FAIL byte_write_ahi: got %h required 01", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'h02)       begin n_fail++; $display("FAIL byte_write_alo: got %h required 02", lg(s+2)); end
    n_checks++; if (lg(s+3) !== 8'hBB)       begin n_fail++; $display("FAIL byte_write_data: got %h required BB", lg(s+3)); end
    n_checks++; if (wmem[16'h0102] !== 8'hBB) begin n_fail++; $display("FAIL byte_write_mem: got %h required BB", wmem[16'h0102]); end
  endtask

  task automatic test_halfword_read();
    int lat; logic [31:0] rd; logic cs; int s;
    s = log_n;
    do_xfer(32'h0000_0020, 32'h0, 4'b1100, 1'b0, lat, rd, cs);
    n_checks++; if (lat !== 82)           begin n_fail++; $display("FAIL half_read_lat: got %0d required 82", lat); end
    n_checks++; if (rd !== 32'hA55A0000)  begin n_fail++; $display("FAIL half_read_rdt: got %h required A55A0000", rd); end
    n_checks++; if (lg(s+1) !== 8'h00)    begin n_fail++; $display("FAIL half_read_ahi: got %h required 00", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'h22)    begin n_fail++; $display("FAIL half_read_alo: got %h required 22", lg(s+2)); end
  endtask

  task automatic test_sel_zero();
    int lat; logic [31:0] rd; logic cs;
    do_xfer(32'h0000_0300, 32'h12345678, 4'b0000, 1'b1, lat, rd, cs);
    n_checks++; if (lat !== 1)            begin n_fail++; $display("FAIL sel0_lat: got %0d required 1", lat); end
    n_checks++; if (cs !== 1'b0)          begin n_fail++; $display("FAIL sel0_cs_activity: got %b required 0", cs); end
    n_checks++; if (rd !== 32'hA55A0000)  begin n_fail++; $display("FAIL sel0_rdt_held: got %h required A55A0000", rd); end
  endtask

  task automatic test_noncontig_write();
    int lat; logic [31:0] rd; logic cs;
    do_xfer(32'h0000_0040, 32'h11223344, 4'b1001, 1'b1, lat, rd, cs);
    n_checks++; if (lat !== 114)              begin n_fail++; $display("FAIL noncontig_lat: got %0d required 114", lat); end
    n_checks++; if (wmem[16'h0040] !== 8'h44) begin n_fail++; $display("FAIL noncontig_b0: got %h required 44", wmem[16'h0040]); end
    n_checks++; if (wmem[16'h0041] !== 8'h33) begin n_fail++; $display("FAIL noncontig_b1: got %h required 33", wmem[16'h0041]); end
    n_checks++; if (wmem[16'h0042] !== 8'h22) begin n_fail++; $display("FAIL noncontig_b2: got %h required 22", wmem[16'h0042]); end
    n_checks++; if (wmem[16'h0043] !== 8'h11) begin n_fail++; $display("FAIL noncontig_b3: got %h required 11", wmem[16'h0043]); end
  endtask

  task automatic test_addr_wrap();
    int lat; logic [31:0] rd; logic cs; int s;
    s = log_n;
    do_xfer(32'h0001_FFFC, 32'hDE000000, 4'b1000, 1'b1, lat, rd, cs);
    n_checks++; if (lat !== 66)               begin n_fail++; $display("FAIL wrap_lat: got %0d required 66", lat); end
    n_checks++; if (lg(s+1) !== 8'hFF)        begin n_fail++; $display("FAIL wrap_ahi: got %h required FF", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'hFF)        begin n_fail++; $display("FAIL wrap_alo: got %h required FF", lg(s+2)); end
    n_checks++; if (wmem[16'hFFFF] !== 8'hDE) begin n_fail++; $display("FAIL wrap_mem: got %h required DE", wmem[16'hFFFF]); end
  endtask

  task automatic test_back_to_back();
    int lat1; int lat2; logic [31:0] rd1; logic [31:0] rd2; logic gap_cs;
    lat1 = -1; lat2 = -1; rd1 = 0; rd2 = 0; gap_cs = 1'b0;
    @(posedge clk); #1;
    wb_adr = 32'h1234; wb_sel = 4'b0011; wb_we = 1'b0; wb_cyc = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (ack) begin lat1 = k; rd1 = rdt_o; break; end
    end
    // Next request presented immediately in the ack cycle, cyc kept high
    wb_adr = 32'h20; wb_sel = 4'b1100;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 1) gap_cs = cs_n;
      if (ack) begin lat2 = k; rd2 = rdt_o; break; end
    end
    wb_cyc = 1'b0; wb_sel = 4'h0;
    n_checks++; if (lat1 !== 82)          begin n_fail++; $display("FAIL b2b_lat1: got %0d required 82", lat1); end
    n_checks++; if (rd1 !== 32'h00002211) begin n_fail++; $display("FAIL b2b_rdt1: got %h required 00002211", rd1); end
    n_checks++; if (gap_cs !== 1'b1)      begin n_fail++; $display("FAIL b2b_cs_gap: got %b required 1", gap_cs); end
    n_checks++; if (lat2 !== 83)          begin n_fail++; $display("FAIL b2b_lat2: got %0d required 83", lat2); end
    n_checks++; if (rd2 !== 32'hA55A0000) begin n_fail++; $display("FAIL b2b_rdt2: got %h required A55A0000", rd2); end
  endtask

  task automatic test_cyc_drop();
    int acks;
    acks = 0;
    @(posedge clk); #1;
    wb_adr = 32'h0200; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    wb_we = 1'b0; wb_sel = 4'h0;
    n_checks++; if (acks !== 0)               begin n_fail++; $display("FAIL cyc_drop_ack: got %0d acks required 0", acks); end
    n_checks++; if (wmem[16'h0200] !== 8'h0D) begin n_fail++; $display("FAIL cyc_drop_b0: got %h required 0D", wmem[16'h0200]); end
    n_checks++; if (wmem[16'h0203] !== 8'hCA) begin n_fail++; $display("FAIL cyc_drop_b3: got %h required CA", wmem[16'h0203]); end
    n_checks++; if (cs_n !== 1'b1)            begin n_fail++; $display("FAIL cyc_drop_cs_n: got %b required 1", cs_n); end
  endtask

  task automatic test_reset_abort();
    int acks; int lat; logic [31:0] rd; logic cs; int s;
    acks = 0;
    @(posedge clk); #1;
    wb_adr = 32'h1234; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cs_n !== 1'b1)    begin n_fail++; $display("FAIL abort_cs_n: got %b required 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)    begin n_fail++; $display("FAIL abort_sclk: got %b required 0", sclk); end
    n_checks++; if (rdt_o !== 32'h0)  begin n_fail++; $display("FAIL abort_rdt: got %h required 0", rdt_o); end
    rst = 1'b0; wb_cyc = 1'b0; wb_sel = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_checks++; if (acks !== 0)       begin n_fail++; $display("FAIL abort_ack: got %0d acks required 0", acks); end
    wait_init();
    s = log_n;
    do_xfer(32'h0000_1234, 32'h0, 4'hF, 1'b0, lat, rd, cs);
    n_checks++; if (lat !== 114)         begin n_fail++; $display("FAIL abort_next_lat: got %0d required 114", lat); end
    n_checks++; if (rd !== 32'h44332211) begin n_fail++; $display("FAIL abort_next_rdt: got %h required 44332211", rd); end
    n_checks++; if (lg(s) !== 8'h03)     begin n_fail++; $display("FAIL abort_next_cmd: got %h required 03", lg(s)); end
    n_checks++; if (lg(s+1) !== 8'h12)   begin n_fail++; $display("FAIL abort_next_ahi: got %h required 12", lg(s+1)); end
    n_checks++; if (lg(s+2) !== 8'h34)   begin n_fail++; $display("FAIL abort_next_alo: got %h required 34", lg(s+2)); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[16'h1234] = 8'h11; rom[16'h1235] = 8'h22;
    rom[16'h1236] = 8'h33; rom[16'h1237] = 8'h44;
    rom[16'h0022] = 8'h5A; rom[16'h0023] = 8'hA5;

    test_reset();
    test_word_read();
    test_byte_write();
    test_halfword_read();
    test_sel_zero();
    test_noncontig_write();
    test_addr_wrap();
    test_back_to_back();
    test_cyc_drop();
    test_reset_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
